// File: rtl/icache_nwa.sv
// N-way set-associative instruction cache with round-robin replacement,
// word-serial refill and a one-cycle response bubble after every fetch.
module icache_nwa #(
  parameter int CACHE_SIZE = 1024,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        proc_valid,
  output logic        proc_ready,
  input  logic [31:0] proc_addr,
  output logic [31:0] proc_rdata,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_rdata,
  output logic        debug_miss
);

  localparam int NUM_SETS = CACHE_SIZE / (NUM_WAYS * NUM_BLOCKS * BLOCK_SIZE);
  localparam int OFF_W    = $clog2(NUM_BLOCKS);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = 32 - IDX_W - OFF_W - 2;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

  state_t r_state, w_next;

  logic [TAG_W-1:0]    r_tag_arr  [NUM_WAYS][NUM_SETS];
  logic [31:0]         r_data_arr [NUM_WAYS][NUM_SETS][NUM_BLOCKS];
  logic [NUM_WAYS-1:0] r_valid    [NUM_SETS];
  logic [WAY_W-1:0]    r_rr       [NUM_SETS];

  logic             r_proc_ready;
  logic [31:0]      r_proc_rdata;
  logic             r_flush_pend;
  logic [TAG_W-1:0] r_tag_q;
  logic [IDX_W-1:0] r_idx_q;
  logic [OFF_W-1:0] r_off_q;
  logic [OFF_W-1:0] r_cnt;
  logic [WAY_W-1:0] r_victim;
  logic             r_victim_was_valid;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_victim;
  logic             w_victim_valid;
  logic             w_last;
  logic             w_beat;
  logic [31:0]      w_fill_word;
  logic             w_unused_addr;

  assign w_off         = proc_addr[2 +: OFF_W];
  assign w_idx         = proc_addr[2 + OFF_W +: IDX_W];
  assign w_tag         = proc_addr[31 -: TAG_W];
  assign w_unused_addr = ^proc_addr[1:0];

  assign w_last = (r_cnt == OFF_W'(NUM_BLOCKS - 1));
  assign w_beat = (r_state == S_REFILL) && mem_req_ready;

  // Words before the current beat are already in the array; the requested word
  // is taken straight from the bus when it is the final one.
  assign w_fill_word = (r_off_q == r_cnt) ? mem_req_rdata
                                          : r_data_arr[r_victim][r_idx_q][r_off_q];

  always_comb begin
    w_hit          = 1'b0;
    w_hit_way      = '0;
    w_victim       = r_rr[w_idx];
    w_victim_valid = 1'b1;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag_arr[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int unsigned w = NUM_WAYS; w > 0; w--) begin
      if (!r_valid[w_idx][w-1]) begin
        w_victim       = WAY_W'(w - 1);
        w_victim_valid = 1'b0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (!flush && proc_valid) w_next = w_hit ? S_RESP : S_REFILL;
      S_REFILL: if (mem_req_ready && w_last) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_proc_ready       <= 1'b0;
      r_proc_rdata       <= '0;
      r_flush_pend       <= 1'b0;
      r_tag_q            <= '0;
      r_idx_q            <= '0;
      r_off_q            <= '0;
      r_cnt              <= '0;
      r_victim           <= '0;
      r_victim_was_valid <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state      <= w_next;
      r_proc_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (flush) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
              r_valid[s] <= '0;
              r_rr[s]    <= '0;
            end
          end else if (proc_valid) begin
            if (w_hit) begin
              r_proc_ready <= 1'b1;
              r_proc_rdata <= r_data_arr[w_hit_way][w_idx][w_off];
            end else begin
              r_tag_q                    <= w_tag;
              r_idx_q                    <= w_idx;
              r_off_q                    <= w_off;
              r_cnt                      <= '0;
              r_victim                   <= w_victim;
              r_victim_was_valid         <= w_victim_valid;
              r_valid[w_idx][w_victim]   <= 1'b0;
            end
          end
        end
        S_REFILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_req_ready) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_valid[r_idx_q][r_victim] <= 1'b1;
              if (r_victim_was_valid) begin
                r_rr[r_idx_q] <= (int'(r_rr[r_idx_q]) == NUM_WAYS - 1) ? '0
                                                                       : r_rr[r_idx_q] + 1'b1;
              end
              r_proc_ready <= 1'b1;
              r_proc_rdata <= w_fill_word;
            end
          end
        end
        S_RESP: begin
          if (flush || r_flush_pend) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
              r_valid[s] <= '0;
              r_rr[s]    <= '0;
            end
          end
          r_flush_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_data_arr[r_victim][r_idx_q][r_cnt] <= mem_req_rdata;
      if (w_last) r_tag_arr[r_victim][r_idx_q] <= r_tag_q;
    end
  end

  assign proc_ready    = r_proc_ready;
  assign proc_rdata    = r_proc_rdata;
  assign mem_req_valid = (r_state == S_REFILL);
  assign debug_miss    = (r_state == S_REFILL);
  assign mem_req_addr  = {r_tag_q, r_idx_q, r_cnt, 2'b00};

endmodule

// File: tb/tb_icache_nwa.sv
// Self-checking bench for icache_nwa: directed vector table, hand-written
// flush/reset sequences and random fetches against a set/way reference model.
module tb_icache_nwa;

  localparam int SETS = 32;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        proc_valid;
  logic        proc_ready;
  logic [31:0] proc_addr;
  logic [31:0] proc_rdata;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata;
  logic        debug_miss;

  icache_nwa #(
    .CACHE_SIZE(1024),
    .NUM_WAYS  (2),
    .NUM_BLOCKS(4),
    .BLOCK_SIZE(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .proc_valid   (proc_valid),
    .proc_ready   (proc_ready),
    .proc_addr    (proc_addr),
    .proc_rdata   (proc_rdata),
    .flush        (flush),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_rdata(mem_req_rdata),
    .debug_miss   (debug_miss)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: per-set valid/tag per way and round-robin pointer.
  bit          m_valid [SETS][WAYS];
  logic [22:0] m_tag   [SETS][WAYS];
  int          m_rr    [SETS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return {w[15:0], ~w[15:0]} ^ {w[31:16], 16'h0000} ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic bit model_access(input logic [31:0] a);
    int          s;
    int          v;
    logic [22:0] t;
    s = int'(a[8:4]);
    t = a[31:9];
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = t;
    return 1'b0;
  endfunction

  // One fetch, serving refill beats with `waits` idle cycles before each.
  // fl_at >= 0 pulses flush during the refill once that many beats are done.
  task automatic do_access(input logic [31:0] a, input int waits, input int fl_at,
                           output bit got, output logic [31:0] data,
                           output int beats, output int lat, output int dbg);
    int          wc;
    bit          fl_done;
    logic [31:0] base;
    wc = 0; fl_done = 0; base = {a[31:4], 4'h0};
    got = 0; data = '0; beats = 0; lat = 0; dbg = 0;
    proc_addr = a;
    proc_valid = 1'b1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      lat++;
      flush = 1'b0;
      mem_req_ready = 1'b0;
      if (proc_ready) begin
        got = 1;
        data = proc_rdata;
      end else begin
        if (debug_miss) dbg++;
        if (mem_req_valid) begin
          chk("refill_addr", mem_req_addr, base + 32'(beats * 4));
          if (fl_at == beats && !fl_done) begin
            flush = 1'b1;
            fl_done = 1;
          end
          if (wc == waits) begin
            mem_req_ready = 1'b1;
            mem_req_rdata = mem_word(base + 32'(beats * 4));
            beats++;
            wc = 0;
          end else begin
            wc++;
          end
        end
      end
    end
    proc_valid = 1'b0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
  endtask

  task automatic run_access(input string nm, input logic [31:0] a, input int waits,
                            input int fl_at, input bit exp_hit);
    bit          got;
    logic [31:0] data;
    int          beats, lat, dbg;
    do_access(a, waits, fl_at, got, data, beats, lat, dbg);
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_data"}, data, mem_word(a));
    chk({nm, "_beats"}, 32'(beats), exp_hit ? 32'd0 : 32'd4);
    chk({nm, "_latency"}, 32'(lat), exp_hit ? 32'd1 : 32'(4 * (waits + 1) + 1));
    chk({nm, "_debug_miss"}, 32'(dbg), exp_hit ? 32'd0 : 32'(4 * (waits + 1)));
    @(negedge clk);
    chk({nm, "_bubble_ready"}, 32'(proc_ready), 32'd0);
    chk({nm, "_rdata_hold"}, proc_rdata, mem_word(a));
  endtask

  task automatic idle_flush();
    proc_addr = 32'h0000_0100;
    proc_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    proc_valid = 1'b0;
    chk("idle_flush_ready", 32'(proc_ready), 32'd0);
    chk("idle_flush_memreq", 32'(mem_req_valid), 32'd0);
    model_flush();
  endtask

  typedef struct {
    logic [31:0] addr;
    int          waits;
    int          fl_at;
    bit          exp_hit;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          h;
    logic [31:0] a;
    logic [31:0] ra;
    int          rb;

    tbl[0]  = '{32'h0000_0104, 0, -1, 1'b0};
    tbl[1]  = '{32'h0000_0108, 0, -1, 1'b1};
    tbl[2]  = '{32'h0000_010C, 0, -1, 1'b1};
    tbl[3]  = '{32'h0000_0300, 0, -1, 1'b0};
    tbl[4]  = '{32'h0000_0500, 0, -1, 1'b0};
    tbl[5]  = '{32'h0000_0304, 0, -1, 1'b1};
    tbl[6]  = '{32'h0000_0100, 0, -1, 1'b0};
    tbl[7]  = '{32'h1234_567B, 3, -1, 1'b0};
    tbl[8]  = '{32'h1234_5670, 0, -1, 1'b1};
    tbl[9]  = '{32'h0000_0808, 1,  2, 1'b0};
    tbl[10] = '{32'h0000_0808, 0, -1, 1'b0};
    tbl[11] = '{32'h0000_0508, 0, -1, 1'b0};

    reset = 1'b1; proc_valid = 1'b0; proc_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_req_rdata = '0;
    model_flush();
    repeat (3) @(negedge clk);
    chk("rst_proc_ready", 32'(proc_ready), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_proc_rdata", proc_rdata, 32'd0);
    chk("rst_debug_miss", 32'(debug_miss), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_access($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].waits, tbl[i].fl_at, tbl[i].exp_hit);
      h = model_access(tbl[i].addr);
      if (tbl[i].fl_at >= 0) model_flush();
    end

    // Flush while idle ignores a concurrent request; the line is then gone.
    run_access("pre_flush_hit", 32'h0000_050C, 0, -1, 1'b1);
    idle_flush();
    run_access("post_flush_miss", 32'h0000_050C, 0, -1, 1'b0);
    h = model_access(32'h0000_050C);

    // Reset after two refill beats abandons the line.
    a = 32'h0000_0C48;
    ra = {a[31:4], 4'h0};
    rb = 0;
    proc_addr = a;
    proc_valid = 1'b1;
    for (int c = 0; c < 50 && rb < 2; c++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        mem_req_ready = 1'b1;
        mem_req_rdata = mem_word(ra + 32'(rb * 4));
        rb++;
      end
    end
    @(negedge clk);
    chk("rst_mid_beats", 32'(rb), 32'd2);
    chk("rst_mid_prereq", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_memreq", 32'(mem_req_valid), 32'd0);
    chk("rst_mid_debug", 32'(debug_miss), 32'd0);
    chk("rst_mid_addr", mem_req_addr, 32'd0);
    proc_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_idle_memreq", 32'(mem_req_valid), 32'd0);
    chk("rst_idle_ready", 32'(proc_ready), 32'd0);
    @(negedge clk);
    mem_req_ready = 1'b0;
    model_flush();
    run_access("rst_refetch", a, 0, -1, 1'b0);
    h = model_access(a);

    // Random fetches over a few conflicting sets.
    for (int i = 0; i < 150; i++) begin
      int r, w, f;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        idle_flush();
      end else begin
        a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4)
          | 32'($urandom_range(0, 15));
        w = int'($urandom_range(0, 2));
        f = (r == 1) ? int'($urandom_range(0, 3)) : -1;
        h = model_access(a);
        run_access($sformatf("rnd%0d", i), a, w, f, h);
        if (!h && f >= 0) model_flush();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
